// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control unit: a Moore FSM that sequences the datapath strobes and ALU code.
// Build option MCCTRL_BNE_EN adds the bne opcode (state BRANCHNE); without it bne is an illegal opcode.
module mips_multicycle_control #(
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       Halted
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MCCTRL_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [2:0] ALU_NOR = 3'b100;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12,
    S_BRANCHNE = 4'd13
  } state_t;

  state_t state;
  logic   pcwrite;
  logic   branch;
  logic   branch_ne;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          case (Op)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_RTYPE:     state <= S_EXECUTE;
            OP_BEQ:       state <= S_BRANCH;
            OP_ADDI:      state <= S_ADDIEXEC;
            OP_J:         state <= S_JUMP;
`ifdef MCCTRL_BNE_EN
            OP_BNE:       state <= S_BRANCHNE;
`endif
            default:      state <= HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
          endcase
        end
        S_MEMADR:   state <= (Op == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:    state <= S_MEMWB;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWR:    state <= S_FETCH;
        S_EXECUTE:  state <= S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_BRANCH:   state <= S_FETCH;
        S_ADDIEXEC: state <= S_ADDIWB;
        S_ADDIWB:   state <= S_FETCH;
        S_JUMP:     state <= S_FETCH;
        S_HALT:     state <= S_HALT;
`ifdef MCCTRL_BNE_EN
        S_BRANCHNE: state <= S_FETCH;
`endif
        default:    state <= S_FETCH;
      endcase
    end
  end

  // Outputs decode from state alone, and are gated by reset so an aborted instruction stops at once.
  always_comb begin
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;
    PCSrc      = 2'b00;
    Halted     = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    branch_ne  = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          IRWrite    = 1'b1;
          ALUSrcB    = 2'b01;
          ALUControl = ALU_ADD;
          pcwrite    = 1'b1;
        end
        S_DECODE: begin
          ALUSrcB    = 2'b11;
          ALUControl = ALU_ADD;
        end
        S_MEMADR, S_ADDIEXEC: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = 2'b10;
          ALUControl = ALU_ADD;
        end
        S_MEMRD: IorD = 1'b1;
        S_MEMWB: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
        end
        S_MEMWR: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
        end
        S_EXECUTE: begin
          ALUSrcA = 1'b1;
          case (Funct)
            6'b100000: ALUControl = ALU_ADD;
            6'b100010: ALUControl = ALU_SUB;
            6'b100100: ALUControl = ALU_AND;
            6'b100101: ALUControl = ALU_OR;
            6'b101010: ALUControl = ALU_SLT;
            6'b100111: ALUControl = ALU_NOR;
            default:   ALUControl = ALU_ADD;
          endcase
        end
        S_ALUWB: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA    = 1'b1;
          ALUControl = ALU_SUB;
          PCSrc      = 2'b01;
          branch     = 1'b1;
        end
`ifdef MCCTRL_BNE_EN
        S_BRANCHNE: begin
          ALUSrcA    = 1'b1;
          ALUControl = ALU_SUB;
          PCSrc      = 2'b01;
          branch_ne  = 1'b1;
        end
`endif
        S_ADDIWB: RegWrite = 1'b1;
        S_JUMP: begin
          PCSrc   = 2'b10;
          pcwrite = 1'b1;
        end
        S_HALT:  Halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign PCEn = pcwrite | (branch & Zero) | (branch_ne & ~Zero);

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control; one instance per HALT_ON_ILLEGAL setting, shared stimulus.
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;

  logic       IorD_a, MemWrite_a, IRWrite_a, RegDst_a, MemtoReg_a, RegWrite_a, ALUSrcA_a, PCEn_a, Halted_a;
  logic [1:0] ALUSrcB_a, PCSrc_a;
  logic [2:0] ALUControl_a;
  logic       IorD_h, MemWrite_h, IRWrite_h, RegDst_h, MemtoReg_h, RegWrite_h, ALUSrcA_h, PCEn_h, Halted_h;
  logic [1:0] ALUSrcB_h, PCSrc_h;
  logic [2:0] ALUControl_h;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mips_multicycle_control #(.HALT_ON_ILLEGAL(1'b0)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
    .IorD(IorD_a), .MemWrite(MemWrite_a), .IRWrite(IRWrite_a), .RegDst(RegDst_a),
    .MemtoReg(MemtoReg_a), .RegWrite(RegWrite_a), .ALUSrcA(ALUSrcA_a), .ALUSrcB(ALUSrcB_a),
    .ALUControl(ALUControl_a), .PCSrc(PCSrc_a), .PCEn(PCEn_a), .Halted(Halted_a)
  );

  mips_multicycle_control #(.HALT_ON_ILLEGAL(1'b1)) dut_h (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
    .IorD(IorD_h), .MemWrite(MemWrite_h), .IRWrite(IRWrite_h), .RegDst(RegDst_h),
    .MemtoReg(MemtoReg_h), .RegWrite(RegWrite_h), .ALUSrcA(ALUSrcA_h), .ALUSrcB(ALUSrcB_h),
    .ALUControl(ALUControl_h), .PCSrc(PCSrc_h), .PCEn(PCEn_h), .Halted(Halted_h)
  );

  // {IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUControl,PCSrc,PCEn,Halted}
  logic [15:0] obs_a, obs_h;
  assign obs_a = {IorD_a, MemWrite_a, IRWrite_a, RegDst_a, MemtoReg_a, RegWrite_a, ALUSrcA_a,
                  ALUSrcB_a, ALUControl_a, PCSrc_a, PCEn_a, Halted_a};
  assign obs_h = {IorD_h, MemWrite_h, IRWrite_h, RegDst_h, MemtoReg_h, RegWrite_h, ALUSrcA_h,
                  ALUSrcB_h, ALUControl_h, PCSrc_h, PCEn_h, Halted_h};

  function automatic logic [15:0] mk(input logic iord, memw, irw, rdst, m2r, rw, srca,
                                     input logic [1:0] srcb, input logic [2:0] aluc,
                                     input logic [1:0] pcs, input logic pcen, halt);
    return {iord, memw, irw, rdst, m2r, rw, srca, srcb, aluc, pcs, pcen, halt};
  endfunction

  function automatic logic [15:0] e_exec(input logic [2:0] aluc);
    return mk(0,0,0,0,0,0,1, 2'b00, aluc, 2'b00, 0, 0);
  endfunction

  function automatic logic [15:0] e_branch(input logic pcen);
    return mk(0,0,0,0,0,0,1, 2'b00, 3'b110, 2'b01, pcen, 0);
  endfunction

  localparam logic [15:0] E_RST    = 16'h0000;
  localparam logic [15:0] E_FETCH  = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 2'b01, 3'b010, 2'b00, 1'b1, 1'b0};
  localparam logic [15:0] E_DECODE = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b11, 3'b010, 2'b00, 1'b0, 1'b0};
  localparam logic [15:0] E_MEMADR = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b10, 3'b010, 2'b00, 1'b0, 1'b0};
  localparam logic [15:0] E_MEMRD  = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0};
  localparam logic [15:0] E_MEMWB  = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0};
  localparam logic [15:0] E_MEMWR  = {1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0};
  localparam logic [15:0] E_ALUWB  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0};
  localparam logic [15:0] E_ADDIEX = E_MEMADR;
  localparam logic [15:0] E_ADDIWB = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0};
  localparam logic [15:0] E_JUMP   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 3'b000, 2'b10, 1'b1, 1'b0};
  localparam logic [15:0] E_HALT   = 16'h0001;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, got, exp);
  endtask

  task automatic chk_both(input string tag, input logic [15:0] ea, input logic [15:0] eh);
    check({tag, "/h0"}, obs_a, ea);
    check({tag, "/h1"}, obs_h, eh);
  endtask

  // Check the current cycle on both instances, then move to the next cycle.
  task automatic cyc(input string tag, input logic [15:0] ea, input logic [15:0] eh);
    chk_both(tag, ea, eh);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    #1;
    chk_both({tag, "_in_reset"}, E_RST, E_RST);
    reset = 1'b0;
    #1;
  endtask

  localparam logic [5:0]  FUNCTS [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                        6'b101010, 6'b100111, 6'b000000};
  localparam logic [2:0]  ALUCS  [7] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b100, 3'b010};

  initial begin
    reset = 1'b1;
    Op    = 6'b000000;
    Funct = 6'b000000;
    Zero  = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_both("reset_hold", E_RST, E_RST);
    end
    reset = 1'b0;
    #1;

    // R-type, every Funct code plus an unlisted one
    for (int i = 0; i < 7; i++) begin
      Op    = 6'b000000;
      Funct = FUNCTS[i];
      cyc("rt_fetch",  E_FETCH,          E_FETCH);
      cyc("rt_decode", E_DECODE,         E_DECODE);
      cyc("rt_exec",   e_exec(ALUCS[i]), e_exec(ALUCS[i]));
      cyc("rt_aluwb",  E_ALUWB,          E_ALUWB);
    end

    Op = 6'b100011;
    cyc("lw_fetch",  E_FETCH,  E_FETCH);
    cyc("lw_decode", E_DECODE, E_DECODE);
    cyc("lw_memadr", E_MEMADR, E_MEMADR);
    cyc("lw_memrd",  E_MEMRD,  E_MEMRD);
    cyc("lw_memwb",  E_MEMWB,  E_MEMWB);

    Op = 6'b101011;
    cyc("sw_fetch",  E_FETCH,  E_FETCH);
    cyc("sw_decode", E_DECODE, E_DECODE);
    cyc("sw_memadr", E_MEMADR, E_MEMADR);
    cyc("sw_memwr",  E_MEMWR,  E_MEMWR);

    Op = 6'b001000;
    cyc("addi_fetch",  E_FETCH,  E_FETCH);
    cyc("addi_decode", E_DECODE, E_DECODE);
    cyc("addi_exec",   E_ADDIEX, E_ADDIEX);
    cyc("addi_wb",     E_ADDIWB, E_ADDIWB);

    Op = 6'b000010;
    cyc("j_fetch",  E_FETCH,  E_FETCH);
    cyc("j_decode", E_DECODE, E_DECODE);
    cyc("j_jump",   E_JUMP,   E_JUMP);

    // beq with Zero toggled inside the BRANCH cycle
    Op   = 6'b000100;
    Zero = 1'b1;
    cyc("beq_fetch",  E_FETCH,  E_FETCH);
    cyc("beq_decode", E_DECODE, E_DECODE);
    chk_both("beq_taken", e_branch(1'b1), e_branch(1'b1));
    Zero = 1'b0;
    #1;
    chk_both("beq_not_taken", e_branch(1'b0), e_branch(1'b0));
    Zero = 1'b1;
    #1;
    chk_both("beq_retaken", e_branch(1'b1), e_branch(1'b1));
    @(posedge clk);
    #1;
    Zero = 1'b0;

    // Illegal opcode: NOP on one instance, HALT on the other
    Op = 6'b111111;
    cyc("ill_fetch",  E_FETCH,  E_FETCH);
    cyc("ill_decode", E_DECODE, E_DECODE);
    cyc("ill_c3",     E_FETCH,  E_HALT);
    cyc("ill_c4",     E_DECODE, E_HALT);
    chk_both("ill_c5", E_FETCH, E_HALT);
    Op = 6'b000000;
    Funct = 6'b100000;
    pulse_reset("ill");
    cyc("ill_recover_fetch",  E_FETCH,  E_FETCH);
    cyc("ill_recover_decode", E_DECODE, E_DECODE);
    cyc("ill_recover_exec",   e_exec(3'b010), e_exec(3'b010));
    cyc("ill_recover_aluwb",  E_ALUWB,  E_ALUWB);

    // Reset asserted in MEMWR drops MemWrite with no clock edge
    Op = 6'b101011;
    cyc("swr_fetch",  E_FETCH,  E_FETCH);
    cyc("swr_decode", E_DECODE, E_DECODE);
    cyc("swr_memadr", E_MEMADR, E_MEMADR);
    chk_both("swr_memwr", E_MEMWR, E_MEMWR);
    #2;
    pulse_reset("swr");
    Op = 6'b000101;
    cyc("swr_after_fetch", E_FETCH, E_FETCH);

    // bne: its own state with the macro, otherwise an illegal opcode
    Zero = 1'b0;
    cyc("bne_decode", E_DECODE, E_DECODE);
`ifdef MCCTRL_BNE_EN
    chk_both("bne_taken", e_branch(1'b1), e_branch(1'b1));
    Zero = 1'b1;
    #1;
    chk_both("bne_not_taken", e_branch(1'b0), e_branch(1'b0));
    @(posedge clk);
    #1;
    Op = 6'b000010;
    cyc("bne_next_fetch", E_FETCH, E_FETCH);
`else
    chk_both("bne_illegal", E_FETCH, E_HALT);
    Op = 6'b000010;
    pulse_reset("bne");
    cyc("bne_recover_fetch", E_FETCH, E_FETCH);
`endif
    cyc("tail_decode", E_DECODE, E_DECODE);
    chk_both("tail_jump", E_JUMP, E_JUMP);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Multicycle MIPS control unit; sits directly upstream of the datapath ALU.
- Decodes Op/Funct into a per-cycle sequence of datapath strobes.
- Drives the ALU's 3-bit ALUControl code and consumes its Zero flag for branches.

Parameters:
HALT_ON_ILLEGAL, 0, 1: an unknown Op enters HALT until reset. 0: an unknown Op returns to FETCH (treated as a NOP).

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
Op  input  6  instruction bits [31:26]; sampled only in DECODE
Funct  input  6  instruction bits [5:0]; used only in EXECUTE
Zero  input  1  ALU Zero flag
IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
MemWrite  output  1  data memory write strobe
IRWrite  output  1  instruction register load
RegDst  output  1  write register select: 1 = rd, 0 = rt
MemtoReg  output  1  write-back select: 1 = memory data, 0 = ALUOut
RegWrite  output  1  register file write strobe
ALUSrcA  output  1  0 = PC, 1 = register A
ALUSrcB  output  2  00 = B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2
ALUControl  output  3  ALU operation code
PCSrc  output  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
PCEn  output  1  PC load enable
Halted  output  1  high while in HALT

Behaviour:
- Moore FSM; state register updates on the rising edge of clk.
- reset high forces state to FETCH asynchronously.
- While reset is high, every output is forced to 0, including ALUControl = 000 and Halted = 0.
- Outputs are decoded from the current state only. Exception: PCEn = PCWrite | (Branch & Zero), combinational in Zero.
- Any strobe not listed for a state is 0.
- ALUControl codes: 010 add, 110 sub, 000 and, 001 or, 111 slt, 100 nor.
- States and outputs:
  - FETCH: IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUControl=010, PCSrc=00, PCWrite=1. Next: DECODE.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUControl=010 (branch target into ALUOut). Next state by Op:
    - 100011 lw or 101011 sw -> MEMADR
    - 000000 R-type -> EXECUTE
    - 000100 beq -> BRANCH
    - 001000 addi -> ADDIEXEC
    - 000010 j -> JUMP
    - any other Op -> HALT if HALT_ON_ILLEGAL, else FETCH
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUControl=010. Next: MEMRD if Op = lw, MEMWR if Op = sw.
  - MEMRD: IorD=1. Next: MEMWB.
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Next: FETCH.
  - MEMWR: IorD=1, MemWrite=1. Next: FETCH.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00. ALUControl from Funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, 100111 -> 100, any other Funct -> 010. Next: ALUWB.
  - ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Next: FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=110, PCSrc=01, Branch=1. Next: FETCH.
  - ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALUControl=010. Next: ADDIWB.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Next: FETCH.
  - JUMP: PCSrc=10, PCWrite=1. Next: FETCH.
  - HALT: all strobes 0, Halted=1. Stays in HALT until reset.
- Latency in cycles, FETCH through last state inclusive: lw 5; sw, R-type, addi 4; beq, j 3.
- Op is required to stay stable from DECODE until the instruction returns to FETCH (IR holds it).
- An unused state encoding recovers to FETCH on the next edge.
- Reset asserted mid-instruction aborts the instruction immediately; no further strobes are issued. The first cycle after reset release is FETCH.

Optional Feature:
- Macro: MCCTRL_BNE_EN.
- Defined: Op 000101 (bne) decodes in DECODE to state BRANCHNE. BRANCHNE outputs are identical to BRANCH except PCEn = PCWrite | (Branch & ~Zero). Next: FETCH. Latency 3 cycles.
- Undefined: Op 000101 is an illegal opcode and follows the HALT_ON_ILLEGAL rule.

Test Plan:
- Reset held 3 cycles, then released -> outputs all 0 during reset; cycle 1 after release: IRWrite=1, PCEn=1, ALUSrcB=01, ALUControl=010.
- Op=000000, Funct=101010 -> EXECUTE shows ALUControl=111, ALUSrcA=1, ALUSrcB=00; ALUWB shows RegWrite=1, RegDst=1; back in FETCH on cycle 5. Repeat for all six Funct codes and Funct=000000 (expect 010).
- Op=100011 (lw) -> IorD=1 in MEMRD; MEMWB shows MemtoReg=1, RegWrite=1; 5 cycles total. Op=101011 (sw) -> MemWrite=1 in cycle 4 only.
- Op=000100 (beq): Zero=1 in BRANCH -> PCEn=1, PCSrc=01, ALUControl=110; Zero=0 -> PCEn=0. Toggle Zero within the cycle and check PCEn follows combinationally.
- Op=111111 with HALT_ON_ILLEGAL=1 -> Halted=1 from cycle 3 onward with all strobes 0; async reset returns to FETCH. With HALT_ON_ILLEGAL=0 -> FETCH on cycle 3.
- Reset asserted in MEMWR -> MemWrite drops to 0 without waiting for a clock edge. With MCCTRL_BNE_EN defined, Op=000101 and Zero=0 -> PCEn=1 in cycle 3.
